// File: rtl/approx_mult_pipe.sv
// Three-stage unsigned multiplier with an optional OR-approximated low-column region
// and a saturating counter of approximate results that differ from the exact product.
module approx_mult_pipe #(
   parameter int W  = 16,
   parameter int K  = W,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   input  logic            in_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*W-1:0]  out_p,
   output logic            out_mode,
   output logic [CW-1:0]   err_cnt,
   input  logic            clr_cnt
);

   localparam int PW = 2 * W;

   function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                             input logic [PW-1:0] z);
      return x ^ y ^ z;
   endfunction

   function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                               input logic [PW-1:0] z);
      return ((x & y) | (x & z) | (y & z)) << 1;
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   logic vld_p1, vld_p2, vld_p3;
   logic ld_p1, ld_p2, ld_p3, adv_p3;

   // A stage loads when empty or when its content moves on this cycle.
   assign adv_p3   = vld_p3 & out_ready;
   assign ld_p3    = vld_p2 & (~vld_p3 | adv_p3);
   assign ld_p2    = vld_p1 & (~vld_p2 | ld_p3);
   assign in_ready = ~vld_p1 | ld_p2;
   assign ld_p1    = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
      end else begin
         vld_p1 <= ld_p1 | (vld_p1 & ~ld_p2);
         vld_p2 <= ld_p2 | (vld_p2 & ~ld_p3);
         vld_p3 <= ld_p3 | (vld_p3 & ~adv_p3);
      end
   end

   // ---- stage 1: operands, mode, partial-product matrix ----
   logic [W-1:0] a_p1, b_p1;
   logic         mode_p1;
   logic [W-1:0] pp_p1 [W];

   always_ff @(posedge clk) begin
      if (ld_p1) begin
         a_p1    <= in_a;
         b_p1    <= in_b;
         mode_p1 <= in_mode;
         for (int i = 0; i < W; i++) begin
            pp_p1[i] <= in_b & {W{in_a[i]}};
         end
      end
   end

   logic [PW-1:0] or_row, row, red_sum, red_carry, nxt_sum, exact_mul;

   // Low columns collapse to a single OR row; remaining columns feed a carry-save chain.
   always_comb begin
      or_row    = '0;
      row       = '0;
      red_sum   = '0;
      red_carry = '0;
      nxt_sum   = '0;
      for (int i = 0; i < W; i++) begin
         for (int j = 0; j < W; j++) begin
            if (mode_p1 && (i + j < K)) begin
               or_row[i+j] = or_row[i+j] | pp_p1[i][j];
            end
         end
      end
      red_sum = or_row;
      for (int i = 0; i < W; i++) begin
         row = '0;
         for (int j = 0; j < W; j++) begin
            if (!(mode_p1 && (i + j < K))) begin
               row[i+j] = pp_p1[i][j];
            end
         end
         nxt_sum   = csa_sum(red_sum, red_carry, row);
         red_carry = csa_carry(red_sum, red_carry, row);
         red_sum   = nxt_sum;
      end
      exact_mul = {{W{1'b0}}, a_p1} * {{W{1'b0}}, b_p1};
   end

   // ---- stage 2: sum/carry rows plus the reference exact product ----
   logic [PW-1:0] sum_p2, carry_p2, exact_p2;
   logic          mode_p2;

   always_ff @(posedge clk) begin
      if (ld_p2) begin
         sum_p2   <= red_sum;
         carry_p2 <= red_carry;
         exact_p2 <= exact_mul;
         mode_p2  <= mode_p1;
      end
   end

   // ---- stage 3: final product ----
   logic [PW-1:0] p_p3, exact_p3;
   logic          mode_p3;

   always_ff @(posedge clk) begin
      if (ld_p3) begin
         p_p3     <= sum_p2 + carry_p2;
         exact_p3 <= exact_p2;
         mode_p3  <= mode_p2;
      end
   end

   // Gating on valid forces zeros the instant reset clears the stage.
   assign out_valid = vld_p3;
   assign out_p     = vld_p3 ? p_p3 : '0;
   assign out_mode  = vld_p3 & mode_p3;

   logic mis_dlv;
   assign mis_dlv = adv_p3 & mode_p3 & (p_p3 != exact_p3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
      end else if (mis_dlv) begin
         err_cnt <= sat_inc(err_cnt);
      end
   end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed and randomized checks of approx_mult_pipe against a column-count
// reference model and an in-order scoreboard.
module tb_approx_mult_pipe;
   localparam int W  = 8;
   localparam int K  = 8;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, in_mode;
   logic [W-1:0]    in_a, in_b;
   logic            out_valid, out_ready, out_mode;
   logic [2*W-1:0]  out_p;
   logic [CW-1:0]   err_cnt;
   logic            clr_cnt;

   approx_mult_pipe #(.W(W), .K(K), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .out_mode(out_mode),
      .err_cnt(err_cnt), .clr_cnt(clr_cnt)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nfail = 0;
   int cyc = 0;
   int delivered = 0;
   logic [2*W-1:0] last_p;
   logic           last_mode;
   logic           acc, saw_valid, saw_full;
   logic [CW-1:0]  err_exp;
   logic [2*W-1:0] q_p[$];
   logic [2*W-1:0] q_x[$];
   logic           q_m[$];

   // Column-by-column product: OR for approximate low columns, full count elsewhere.
   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic mode);
      longint total = 0;
      int cnt;
      for (int c = 0; c < 2*W; c++) begin
         cnt = 0;
         for (int i = 0; i < W; i++)
            if (c - i >= 0 && c - i < W)
               if (a[i] && b[c-i]) cnt++;
         if (mode && c < K) total += (cnt != 0 ? longint'(1) : longint'(0)) << c;
         else               total += longint'(cnt) << c;
      end
      return total[2*W-1:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check("err_cnt", 32'(err_cnt), 32'(err_exp));
      saw_valid = out_valid;
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (out_valid) begin
         if (q_p.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            check("out_p", 32'(out_p), 32'(q_p[0]));
            check("out_mode", 32'(out_mode), 32'(q_m[0]));
            if (out_ready) begin
               last_p = out_p;
               last_mode = out_mode;
               delivered++;
               if (q_m[0] && q_p[0] != q_x[0] && err_exp != '1) err_exp++;
               void'(q_p.pop_front());
               void'(q_m.pop_front());
               void'(q_x.pop_front());
            end
         end
      end
      if (clr_cnt) err_exp = '0;
      if (acc) begin
         q_p.push_back(ref_prod(in_a, in_b, in_mode));
         q_m.push_back(in_mode);
         q_x.push_back({{W{1'b0}}, in_a} * {{W{1'b0}}, in_b});
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && q_p.size() > 0; k++) tick();
      check("drain_empty", 32'(q_p.size()), 32'd0);
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode);
      in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic lat_test(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                           output int lat);
      send(a, b, mode);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (saw_valid && lat == 0) lat = k;
      end
   endtask

   initial begin
      int lat;
      int d0;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
      out_ready = 1'b1; clr_cnt = 1'b0; err_exp = '0; saw_full = 1'b0;
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_p", 32'(out_p), 32'd0);
      check("rst_out_mode", 32'(out_mode), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // exact mode, full-scale operands
      lat_test(8'hFF, 8'hFF, 1'b0, lat);
      check("latency_exact", 32'(lat), 32'd3);
      drain();
      check("p_exact_ff", 32'(last_p), 32'h0000FE01);
      check("err_after_exact", 32'(err_cnt), 32'd0);

      // approximate mode, mismatching result
      send(8'hFF, 8'hFF, 1'b1);
      drain();
      check("p_approx_ff", 32'(last_p), 32'h0000F7FF);
      check("mode_approx_ff", 32'(last_mode), 32'd1);
      check("err_after_ff", 32'(err_cnt), 32'd1);

      // approximate mode, result equals exact
      send(8'h03, 8'h05, 1'b1);
      drain();
      check("p_approx_3x5", 32'(last_p), 32'h0000000F);
      check("err_after_3x5", 32'(err_cnt), 32'd1);

      // full throughput
      in_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_a = W'($urandom); in_b = W'($urandom); in_mode = 1'($urandom);
         tick();
         check("tput_accept", 32'(acc), 32'd1);
         if (k >= 4) check("tput_out_valid", 32'(saw_valid), 32'd1);
      end
      in_valid = 1'b0;
      drain();

      // 10 back-to-back transactions, out_ready 1-on/2-off
      d0 = delivered;
      saw_full = 1'b0;
      for (int n = 0, k = 0; n < 10 && k < 200; k++) begin
         out_ready = (cyc % 3 == 0);
         in_valid = 1'b1;
         in_a = W'($urandom); in_b = W'($urandom); in_mode = 1'($urandom);
         tick();
         if (acc) n++;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 100 && q_p.size() > 0; k++) begin
         out_ready = (cyc % 3 == 0);
         tick();
      end
      out_ready = 1'b1;
      check("stream_delivered", 32'(delivered - d0), 32'd10);
      check("stream_in_ready_low", 32'(saw_full), 32'd1);

      // random traffic with invalid-cycle garbage and occasional clears
      for (int k = 0; k < 80; k++) begin
         in_valid = 1'($urandom); in_mode = 1'($urandom);
         in_a = W'($urandom); in_b = W'($urandom);
         out_ready = ($urandom % 4) != 0;
         clr_cnt = ($urandom % 16) == 0;
         tick();
      end
      in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
      drain();

      // saturation and clear priority
      clr_cnt = 1'b1; tick(); clr_cnt = 1'b0; tick();
      check("err_cleared", 32'(err_cnt), 32'd0);
      for (int k = 0; k < 4; k++) send(8'hFF, 8'hFF, 1'b1);
      drain();
      check("err_saturated", 32'(err_cnt), 32'd3);
      send(8'hFF, 8'hFF, 1'b1);
      tick(); tick();
      clr_cnt = 1'b1;
      tick();
      check("clr_prio_delivery", 32'(saw_valid), 32'd1);
      clr_cnt = 1'b0;
      tick();
      check("err_clr_prio", 32'(err_cnt), 32'd0);

      // reset with three transactions in flight
      out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0);
      send(8'h33, 8'h44, 1'b1);
      send(8'h55, 8'h66, 1'b0);
      rst_n = 1'b0;
      #1;
      check("inrst_out_valid", 32'(out_valid), 32'd0);
      check("inrst_out_p", 32'(out_p), 32'd0);
      check("inrst_out_mode", 32'(out_mode), 32'd0);
      check("inrst_in_ready", 32'(in_ready), 32'd1);
      check("inrst_err_cnt", 32'(err_cnt), 32'd0);
      q_p.delete(); q_m.delete(); q_x.delete();
      err_exp = '0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      lat_test(8'h12, 8'h34, 1'b0, lat);
      check("latency_after_reset", 32'(lat), 32'd3);
      drain();
      check("p_after_reset", 32'(last_p), 32'h000003A8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
